// File: rtl/gpio_led_fader_pkg.sv
// Shared types and helpers for the GPIO LED fader.
// duty_t is a container wide enough for any supported PWM_BITS (up to DUTY_W).
// Each instance narrows the result back to its own PWM width.
package gpio_led_pkg;

  localparam int DUTY_W = 16;

  typedef logic [DUTY_W-1:0] duty_t;

  // All-ones in the container.
  // An instance shifts this right to get its own MAX.
  localparam duty_t DUTY_MAX = '1;

  // Move duty one step toward max (up) or zero (down), clamping at the ends.
  function automatic duty_t sat_step(input duty_t duty, input logic up,
                                     input duty_t step, input duty_t max);
    duty_t res;
    if (up) begin
      res = (step >= max - duty) ? max : duty + step;
    end else begin
      res = (step >= duty) ? '0 : duty - step;
    end
    return res;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_led_fader_input_debouncer.sv
// One pad input channel.
// A flop chain synchronises the pad. A stability counter then accepts a level
// change only after it has held for DEBOUNCE_CYCLES cycles. Rise/fall pulses are
// registered together with the accepted state.
module input_debouncer
  import gpio_led_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic state,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   s;
  logic [CNT_W-1:0]       cnt;

  assign s = sync_p[SYNC_STAGES-1];

  // Synchroniser chain: shift the raw pad in, oldest sample is the settled level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], pad};
    end
  end

  // Accept a new level once it differs for DEBOUNCE_CYCLES in a row; pulse on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s != state) begin
        if (cnt == CNT_LAST) begin
          state <= s;
          cnt   <= '0;
          rise  <= s;
          fall  <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gpio_led_fader.sv
// GPIO conditioner between the SoC gpioA port and the board pins.
// LEDs are driven either directly (registered) or through a PWM fade whose duty
// ramps toward the written target once per PWM period. Pad inputs are
// synchronised and debounced back into the gpio read vector, with edge pulses.
module gpio_led_fader
  import gpio_led_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int NUM_INPUTS      = 4,
  parameter int PWM_BITS        = 8,
  parameter int PRESCALE        = 64,
  parameter int FADE_STEP       = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  io_mainClk,
  input  logic                  io_asyncReset_n,
  input  logic [NUM_LEDS-1:0]   io_gpio_write,
  input  logic [NUM_LEDS-1:0]   io_gpio_writeEnable,
  input  logic                  io_fade_en,
  input  logic [NUM_INPUTS-1:0] io_pad_in,
  output logic [NUM_LEDS-1:0]   io_led,
  output logic [NUM_INPUTS-1:0] io_gpio_read,
  output logic [NUM_INPUTS-1:0] io_rise,
  output logic [NUM_INPUTS-1:0] io_fall
);

  // Full-scale duty in the wide container, and the same value at PWM width.
  localparam duty_t                MAX_W    = DUTY_MAX >> (DUTY_W - PWM_BITS);
  localparam duty_t                STEP     = duty_t'(FADE_STEP);
  localparam logic [PWM_BITS-1:0]  DUTY_TOP = '1;
  localparam int                   PS_W     = cnt_width(PRESCALE);
  localparam logic [PS_W-1:0]      PS_LAST  = PS_W'(PRESCALE - 1);

  logic [NUM_LEDS-1:0]                tgt;
  logic [PS_W-1:0]                    presc;
  logic                               presc_wrap;
  logic                               fade_tick;
  logic [PWM_BITS-1:0]                pwm_cnt;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty_next;
  logic [NUM_LEDS-1:0]                led_next;

  // A channel without write enable is treated as off.
  assign tgt        = io_gpio_write & io_gpio_writeEnable;
  assign presc_wrap = (presc == PS_LAST);
  // One tick per full PWM period, on the last prescaler cycle of the last count.
  assign fade_tick  = presc_wrap && (pwm_cnt == DUTY_TOP);

  // Prescaler divides the clock down to the PWM counter rate
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      presc <= '0;
    end else if (presc_wrap) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // PWM counter advances once per prescaler wrap and rolls over naturally at MAX
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      pwm_cnt <= '0;
    end else if (presc_wrap) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    logic [PWM_BITS-1:0] tgt_duty;
    logic [PWM_BITS-1:0] ramp_duty;

    assign tgt_duty  = tgt[i] ? DUTY_TOP : '0;
    assign ramp_duty = PWM_BITS'(sat_step(duty_t'(duty[i]), tgt[i], STEP, MAX_W));

    // Direct mode keeps duty snapped to the target, so entering fade mode never
    // jumps. In fade mode duty only moves on a tick. A reversed target therefore
    // turns the ramp around at the next tick instead of restarting it.
    assign duty_next[i] = !io_fade_en ? tgt_duty :
                          (fade_tick ? ramp_duty : duty[i]);

    // Full-scale duty is forced on so MAX is steady rather than 15/16 lit.
    assign led_next[i]  = io_fade_en ?
                          ((duty[i] == DUTY_TOP) || (pwm_cnt < duty[i])) :
                          tgt[i];
  end

  // Per-LED duty registers
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      duty <= '0;
    end else begin
      duty <= duty_next;
    end
  end

  // Registered LED drive: target in direct mode, PWM compare in fade mode
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      io_led <= '0;
    end else begin
      io_led <= led_next;
    end
  end

  for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_in
    input_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (io_mainClk),
      .rst_n (io_asyncReset_n),
      .pad   (io_pad_in[j]),
      .state (io_gpio_read[j]),
      .rise  (io_rise[j]),
      .fall  (io_fall[j])
    );
  end

endmodule

// File: tb/tb_gpio_led_fader.sv
// Directed bench for gpio_led_fader with a small PWM configuration.
// Expected values are queued as each stimulus step is applied. They are popped
// and compared when the corresponding DUT output is sampled on the falling edge.
module tb_gpio_led_fader;

  localparam int NL = 8;
  localparam int NI = 4;
  localparam int PB = 4;
  localparam int PS = 2;
  localparam int FS = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int PERIOD_CLKS = (1 << PB) * PS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NL-1:0] wr;
  logic [NL-1:0] we;
  logic          fade_en;
  logic [NI-1:0] pad;
  logic [NL-1:0] led;
  logic [NI-1:0] rd;
  logic [NI-1:0] rise;
  logic [NI-1:0] fall;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  gpio_led_fader #(
    .NUM_LEDS        (NL),
    .NUM_INPUTS      (NI),
    .PWM_BITS        (PB),
    .PRESCALE        (PS),
    .FADE_STEP       (FS),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .io_mainClk          (clk),
    .io_asyncReset_n     (rst_n),
    .io_gpio_write       (wr),
    .io_gpio_writeEnable (we),
    .io_fade_en          (fade_en),
    .io_pad_in           (pad),
    .io_led              (led),
    .io_gpio_read        (rd),
    .io_rise             (rise),
    .io_fall             (fall)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h", act);
    end else begin
      e = sb.pop_front();
      assert (act === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, act, e.val);
      end
    end
  endtask

  // Bounded wait for the next fade tick; leaves us just after the tick edge.
  task automatic sync_tick(input string tag);
    bit ok;
    ok = 1'b0;
    expect_val(tag, 32'd1);
    for (int k = 0; k < 3 * PERIOD_CLKS; k++) begin
      @(negedge clk);
      if (dut.fade_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    observe(32'(ok));
    @(negedge clk);
  endtask

  // Count led0-high cycles over one full PWM period (2*duty, or all of it at MAX).
  task automatic window(input string tag, input int exp_hi);
    int hi;
    expect_val(tag, 32'(exp_hi));
    hi = 0;
    for (int k = 0; k < PERIOD_CLKS; k++) begin
      @(negedge clk);
      if (led[0] === 1'b1) hi++;
    end
    observe(32'(hi));
  endtask

  initial begin
    // 1: reset with everything driven high
    rst_n   = 1'b0;
    pad     = '1;
    wr      = '1;
    we      = '1;
    fade_en = 1'b0;
    repeat (3) @(negedge clk);
    expect_val("rst_led", 32'h0);   observe(32'(led));
    expect_val("rst_read", 32'h0);  observe(32'(rd));
    expect_val("rst_rise", 32'h0);  observe(32'(rise));
    expect_val("rst_fall", 32'h0);  observe(32'(fall));
    expect_val("rst_duty0", 32'h0); observe(32'(dut.duty[0]));
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      expect_val("rel_read_low", 32'h0);
      @(negedge clk);
      observe(32'(rd));
    end
    expect_val("rel_read_6", 32'hF);
    expect_val("rel_rise_6", 32'hF);
    @(negedge clk);
    observe(32'(rd));
    observe(32'(rise));

    // 2: direct mode
    wr  = 8'hA5;
    we  = 8'hFF;
    pad = '0;
    expect_val("dir_hold", 32'hFF);
    #1 observe(32'(led));
    expect_val("dir_a5", 32'hA5);
    expect_val("dir_duty0_max", 32'hF);
    expect_val("dir_duty1_zero", 32'h0);
    @(negedge clk);
    observe(32'(led));
    observe(32'(dut.duty[0]));
    observe(32'(dut.duty[1]));
    we = 8'h0F;
    expect_val("dir_we0f", 32'h05);
    @(negedge clk);
    observe(32'(led));

    // 3: fade up from zero
    wr = 8'h00;
    we = 8'hFF;
    @(negedge clk);
    wr      = 8'h01;
    fade_en = 1'b1;
    sync_tick("tick_up");
    window("up_d4", 8);
    window("up_d8", 16);
    window("up_d12", 24);
    window("up_d15", 32);
    window("up_hold15", 32);

    // fade -> direct: LED follows target next clock, duty snaps
    fade_en = 1'b0;
    wr      = 8'h00;
    expect_val("sw_led", 32'h00);
    expect_val("sw_duty0", 32'h0);
    @(negedge clk);
    observe(32'(led));
    observe(32'(dut.duty[0]));

    // 4: reversal at duty 8
    wr      = 8'h01;
    fade_en = 1'b1;
    sync_tick("tick_rev");
    window("rev_d4", 8);
    wr = 8'h00;
    window("rev_d8", 16);
    window("rev_d4b", 8);
    window("rev_d0", 0);
    window("rev_d0_hold", 0);
    expect_val("rev_duty0", 32'h0);
    observe(32'(dut.duty[0]));

    // 5: debounce of pad0 rising edge
    pad = 4'h1;
    for (int k = 1; k <= 5; k++) begin
      expect_val("deb_wait", 32'h0);
      @(negedge clk);
      observe(32'({rd[0], rise[0]}));
    end
    expect_val("deb_edge6", 32'h3);
    @(negedge clk);
    observe(32'({rd[0], rise[0]}));
    expect_val("deb_after", 32'h2);
    @(negedge clk);
    observe(32'({rd[0], rise[0]}));
    // 3-clock low glitch must be ignored
    pad = 4'h0;
    repeat (3) @(negedge clk);
    pad = 4'h1;
    for (int k = 0; k < 10; k++) begin
      expect_val("glitch_ignored", 32'h4);
      @(negedge clk);
      observe(32'({rd[0], fall[0], rise[0]}));
    end

    // 6: async reset mid-fade
    pad = 4'h0;
    fade_en = 1'b0;
    repeat (10) @(negedge clk);
    wr      = 8'h01;
    fade_en = 1'b1;
    sync_tick("tick_mid");
    window("mid_d4", 8);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    expect_val("arst_led", 32'h0);
    expect_val("arst_duty0", 32'h0);
    expect_val("arst_read", 32'h0);
    #1;
    observe(32'(led));
    observe(32'(dut.duty[0]));
    observe(32'(rd));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_val("rel_no_pulse", 32'h0);
      @(negedge clk);
      observe(32'({rise, fall}));
    end
    sync_tick("tick_restart");
    window("restart_d4", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
